// File: rtl/rega_zone_sequencer_pkg.sv
// rtl/rega_zone_sequencer_pkg.sv - shared state encoding, selector constant and zone search helper
package rega_zone_sequencer_pkg;

    localparam int ZONES = 7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_WATER  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [2:0] SEL_NONE = 3'b000;

    // Returns {found, index} of the lowest set mask bit at or above ptr; ptr = 7 finds nothing.
    function automatic logic [3:0] find_zone(input logic [ZONES-1:0] mask, input logic [2:0] ptr);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = ZONES - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= ptr)) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rega_tick_prescaler.sv
// rtl/rega_tick_prescaler.sv - free-running 0..TICK_DIV-1 counter with a one-cycle tick on wrap
module rega_tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick = !clear && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rega_zone_sequencer.sv
// rtl/rega_zone_sequencer.sv - irrigation zone sequencer driving a 1-to-7 valve demux
// Optional REGA_ZONE_GAP_EN inserts a GAP_CYCLES settle gap after every watered zone.
module rega_zone_sequencer
    import rega_zone_sequencer_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int DUR_W      = 8,
    parameter int GAP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [6:0]       zone_mask,
    input  logic [DUR_W-1:0] duration,
    output logic [2:0]       S,
    output logic             valve_en,
    output logic             busy,
    output logic             done
);

    logic [2:0]       state_q, state_d;
    logic [6:0]       mask_q, mask_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       s_q, s_d;
    logic             valve_en_q, valve_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [3:0] search;
    logic       found;
    logic [2:0] found_idx;
    logic       tick;

`ifdef REGA_ZONE_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`else
    logic unused_gap_cycles;
    assign unused_gap_cycles = (GAP_CYCLES != 0);
`endif

    assign search    = find_zone(mask_q, ptr_q);
    assign found     = search[3];
    assign found_idx = search[2:0];

    rega_tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(state_q != ST_WATER),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            dur_q      <= '0;
            dur_cnt_q  <= '0;
            ptr_q      <= '0;
            s_q        <= SEL_NONE;
            valve_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef REGA_ZONE_GAP_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            dur_q      <= dur_d;
            dur_cnt_q  <= dur_cnt_d;
            ptr_q      <= ptr_d;
            s_q        <= s_d;
            valve_en_q <= valve_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef REGA_ZONE_GAP_EN
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        dur_d     = dur_q;
        dur_cnt_d = dur_cnt_q;
        ptr_d     = ptr_q;
`ifdef REGA_ZONE_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    mask_d  = zone_mask;
                    dur_d   = duration;
                    ptr_d   = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (found && (dur_q != '0)) begin
                    ptr_d     = found_idx + 3'd1;
                    dur_cnt_d = dur_q;
                    state_d   = ST_WATER;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WATER: begin
                if (tick) begin
                    dur_cnt_d = dur_cnt_q - 1'b1;
                    if (dur_cnt_q == DUR_W'(1)) begin
`ifdef REGA_ZONE_GAP_EN
                        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                        state_d   = ST_GAP;
`else
                        state_d   = ST_SELECT;
`endif
                    end
                end
            end
`ifdef REGA_ZONE_GAP_EN
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_SELECT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over every other transition, including the DONE pulse.
        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs are registered from the next state, so they change on the same edge as the state.
    always_comb begin
        s_d        = SEL_NONE;
        valve_en_d = 1'b0;
        if (state_d == ST_WATER) begin
            valve_en_d = 1'b1;
            s_d        = (state_q == ST_WATER) ? s_q : (found_idx + 3'd1);
        end
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    assign S        = s_q;
    assign valve_en = valve_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_rega_zone_sequencer.sv
// tb/tb_rega_zone_sequencer.sv - directed self-checking bench for rega_zone_sequencer
module tb_rega_zone_sequencer;

    localparam int TICK_DIV = 4;
`ifdef REGA_ZONE_GAP_EN
    localparam int GAPN = 3;
`else
    localparam int GAPN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [6:0] zone_mask = '0;
    logic [7:0] duration = '0;
    logic [2:0] S;
    logic       valve_en;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    rega_zone_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .DUR_W     (8),
        .GAP_CYCLES(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .zone_mask(zone_mask),
        .duration (duration),
        .S        (S),
        .valve_en (valve_en),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({S, valve_en, busy, done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_async: got S=%b valve_en=%b busy=%b done=%b, want all 0", S, valve_en, busy, done);
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({S, valve_en, busy, done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_idle: got S=%b valve_en=%b busy=%b done=%b, want all 0", S, valve_en, busy, done);
        end
    endtask

    // Expected trace for a two-zone run with duration 2: SELECT, A x8, gap, SELECT, B x8, gap, SELECT, DONE, idle.
    task automatic run_two_zone_trace(input logic [6:0] mask, input logic [2:0] s_a, input logic [2:0] s_b);
        logic [2:0] exp_s[$];
        logic       exp_d[$];
        logic       exp_b[$];
        exp_s.push_back(3'd0); exp_d.push_back(1'b0); exp_b.push_back(1'b1);
        repeat (8) begin exp_s.push_back(s_a); exp_d.push_back(1'b0); exp_b.push_back(1'b1); end
        repeat (GAPN + 1) begin exp_s.push_back(3'd0); exp_d.push_back(1'b0); exp_b.push_back(1'b1); end
        repeat (8) begin exp_s.push_back(s_b); exp_d.push_back(1'b0); exp_b.push_back(1'b1); end
        repeat (GAPN + 1) begin exp_s.push_back(3'd0); exp_d.push_back(1'b0); exp_b.push_back(1'b1); end
        exp_s.push_back(3'd0); exp_d.push_back(1'b1); exp_b.push_back(1'b1);
        repeat (2) begin exp_s.push_back(3'd0); exp_d.push_back(1'b0); exp_b.push_back(1'b0); end

        zone_mask = mask;
        duration  = 8'd2;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < exp_s.size(); i++) begin
            checks++;
            if (S !== exp_s[i] || valve_en !== (exp_s[i] != 3'd0)) begin
                failures++;
                $display("FAIL trace_sel cycle %0d: got S=%b valve_en=%b, want S=%b valve_en=%b",
                         i, S, valve_en, exp_s[i], (exp_s[i] != 3'd0));
            end
            checks++;
            if (done !== exp_d[i] || busy !== exp_b[i]) begin
                failures++;
                $display("FAIL trace_status cycle %0d: got done=%b busy=%b, want done=%b busy=%b",
                         i, done, busy, exp_d[i], exp_b[i]);
            end
            step();
        end
    endtask

    task automatic test_two_zones();
        run_two_zone_trace(7'b0000101, 3'b001, 3'b011);
    endtask

    task automatic test_empty_mask(input logic [6:0] mask, input logic [7:0] dur);
        logic [2:0] exp_db[3] = '{3'b001, 3'b011, 3'b000};
        zone_mask = mask;
        duration  = dur;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({valve_en, done, busy} !== exp_db[i] || S !== 3'd0) begin
                failures++;
                $display("FAIL empty_run mask=%b dur=%0d cycle %0d: got valve_en,done,busy=%b S=%b, want %b S=000",
                         mask, dur, i, {valve_en, done, busy}, S, exp_db[i]);
            end
            step();
        end
    endtask

    task automatic test_stop();
        int p0;
        logic seen_done;
        p0 = 19 + 2 * GAPN;
        seen_done = 1'b0;
        zone_mask = 7'h7F;
        duration  = 8'd2;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= p0 + 2; i++) begin
            step();
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (S !== 3'b011 || valve_en !== 1'b1) begin
            failures++;
            $display("FAIL stop_pre: got S=%b valve_en=%b, want S=011 valve_en=1", S, valve_en);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        if (done) seen_done = 1'b1;
        checks++;
        if ({S, valve_en, busy, done} !== 6'b0) begin
            failures++;
            $display("FAIL stop_abort: got S=%b valve_en=%b busy=%b done=%b, want all 0", S, valve_en, busy, done);
        end
        step();
        if (done) seen_done = 1'b1;
        checks++;
        if (seen_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_no_done: got seen_done=%b busy=%b, want 0 0", seen_done, busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (S !== 3'b001 || valve_en !== 1'b1) begin
            failures++;
            $display("FAIL stop_restart: got S=%b valve_en=%b, want S=001 valve_en=1", S, valve_en);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        zone_mask = 7'h7F;
        duration  = 8'd2;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (S !== 3'b001 || valve_en !== 1'b1) begin
            failures++;
            $display("FAIL busy_zone0: got S=%b valve_en=%b, want S=001 valve_en=1", S, valve_en);
        end
        start     = 1'b1;
        zone_mask = 7'h00;
        duration  = 8'd0;
        repeat (9 + GAPN) step();
        checks++;
        if (S !== 3'b010 || valve_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_ignore: got S=%b valve_en=%b busy=%b, want S=010 valve_en=1 busy=1", S, valve_en, busy);
        end
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({S, valve_en, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_water: got S=%b valve_en=%b busy=%b, want all 0", S, valve_en, busy);
        end
        #1 reset = 1'b0;
        step();
        checks++;
        if ({S, valve_en, busy, done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_after: got S=%b valve_en=%b busy=%b done=%b, want all 0", S, valve_en, busy, done);
        end
    endtask

`ifdef REGA_ZONE_GAP_EN
    task automatic test_gap();
        run_two_zone_trace(7'b1000001, 3'b001, 3'b111);
    endtask
`endif

    initial begin
        test_reset();
        test_two_zones();
        test_empty_mask(7'h00, 8'd5);
        test_empty_mask(7'h7F, 8'd0);
        test_stop();
        test_async_reset();
`ifdef REGA_ZONE_GAP_EN
        test_gap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
